avg_ctrl_s_axi: RTL and testbench
=================================

Name: avg_ctrl_s_axi

Overview:
- AXI4-Lite slave (responder) control/status register file for the averager core.
- Terminates the PS/VIP master's register writes and reads at the averager base address.
- Drives ap_start, num_samples and num_avgs into the core; returns handshake status and the running average count.
- Register map and bit layout match the team's HLS control convention: writing 129 to 0x00 starts the core with auto-restart.

Parameters:
- C_ADDR_WIDTH, 6, AXI address width in bits. Only bits [5:2] are decoded.
- C_DATA_WIDTH, 32, AXI data width. Fixed at 32; any other value is unsupported.

Ports:
- ap_clk  in  1  single clock for the AXI side and the core side.
- ap_rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  C_ADDR_WIDTH  write address.
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake.
- s_axi_wdata  in  32 / s_axi_wstrb  in  4  write data and byte strobes.
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake.
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response.
- s_axi_araddr  in  C_ADDR_WIDTH / s_axi_arvalid  in  1 / s_axi_arready  out  1  read address.
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read data.
- ap_start  out  1  start request to the core.
- ap_done  in  1  one-cycle pulse from the core: run complete.
- ap_ready  in  1  one-cycle pulse from the core: start accepted.
- ap_idle  in  1  core idle level.
- num_samples  out  32  register 0x10.
- num_avgs  out  32  register 0x18.
- avg_count  in  32  running average count, readable at 0x38.

Behaviour:
- Register map (unmapped addresses: writes ignored, reads return 0):
  - 0x00 CTRL: bit0 ap_start (RW); bit1 ap_done (read-to-clear); bit2 ap_idle (RO, live); bit3 ap_ready (read-to-clear); bit7 auto_restart (RW).
  - 0x10 num_samples (RW); 0x18 num_avgs (RW); 0x38 avg_count (RO, sampled on the AR handshake).
- Reset values: all registers 0; awready=wready=arready=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0; ap_start=0.
- Write FSM, states WRIDLE -> WRDATA -> WRRESP -> WRIDLE:
  - awready=1 only in WRIDLE; address latched on the AW handshake.
  - wready=1 only in WRDATA; register updated on the W handshake, byte-wise per wstrb.
  - bvalid=1 in WRRESP and held until bready. bresp always OKAY (00).
  - AW and W presented together: AW taken in cycle n, W in cycle n+1, bvalid in n+2.
- Read FSM, states RDIDLE -> RDDATA -> RDIDLE:
  - arready=1 in RDIDLE. rvalid is asserted the cycle after the AR handshake.
  - rdata and rvalid are held stable until rready. rresp is always OKAY.
- ap_start:
  - Set by a CTRL write with wstrb[0]=1 and wdata[0]=1.
  - Cleared on an ap_ready pulse when auto_restart=0.
  - Stays 1 on ap_ready when auto_restart=1.
  - A write of 0 to bit0 has no effect.
- auto_restart: written from wdata[7] when wstrb[0]=1.
- ap_done / ap_ready status bits:
  - Each is set by its input pulse.
  - Each is cleared on the AR handshake for address 0x00; the returned data shows the pre-clear value.
  - A set pulse and a clear in the same cycle leave the bit set.
- ap_rst_n low mid-transaction: both FSMs return to idle immediately and every valid output drops. The master must reissue the transaction.

Optional Feature:
- Macro: AVG_CTRL_IRQ_EN.
- When defined, the block adds:
  - Output port interrupt (1 bit).
  - 0x04 GIE, bit0.
  - 0x08 IER, bits[1:0] = {ready, done}.
  - 0x0C ISR, bits[1:0]: set by the matching event when its IER bit is 1; each bit toggles when 1 is written to it.
  - interrupt = GIE & |ISR, registered, reset 0.
- When undefined:
  - No interrupt port.
  - 0x04, 0x08 and 0x0C read 0 and ignore writes.

Test Plan:
- Reset, then read 0x00 with ap_idle=1 -> rdata=0x00000004, rresp=00; bvalid=rvalid=0 during reset.
- Write 0x10=110592, 0x18=5, read both back -> num_samples=110592, num_avgs=5, same values returned; write with wstrb=0001 of 0xFFFFFFFF to 0x18 -> reads 0x000000FF.
- Write 0x00=129 -> ap_start=1; pulse ap_ready -> ap_start stays 1; write 0x00=0, pulse ap_ready -> ap_start=0.
- Write 0x00=1 (auto_restart=0), pulse ap_ready then ap_done -> ap_start=0; first CTRL read returns bits1,3 set; second read has them clear.
- Hold rready=0 for 10 cycles after an AR to 0x38 with avg_count=3 changing to 4 -> rvalid held, rdata=3 stable; arready=0 throughout.
- AVG_CTRL_IRQ_EN: GIE=1, IER=1, pulse ap_done -> interrupt=1 one cycle later; write ISR=1 -> interrupt=0.

Source files
------------

// File: rtl/avg_ctrl_s_axi_if.sv
// AXI4-Lite channel bundle for the averager control register file.
interface avg_ctrl_s_axi_if #(
  parameter int unsigned C_ADDR_WIDTH = 6
) ();
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             wdata;
  logic [3:0]              wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [C_ADDR_WIDTH-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/avg_ctrl_s_axi.sv
// AXI4-Lite control/status register file for the averager core.
// Define AVG_CTRL_IRQ_EN to add GIE/IER/ISR registers and the interrupt output.
module avg_ctrl_s_axi #(
  parameter int unsigned C_ADDR_WIDTH = 6,
  parameter int unsigned C_DATA_WIDTH = 32
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  avg_ctrl_s_axi_if.slave         s_axi,
  output logic                    ap_start,
  input  logic                    ap_done,
  input  logic                    ap_ready,
  input  logic                    ap_idle,
  output logic [C_DATA_WIDTH-1:0] num_samples,
  output logic [C_DATA_WIDTH-1:0] num_avgs,
`ifdef AVG_CTRL_IRQ_EN
  output logic                    interrupt,
`endif
  input  logic [C_DATA_WIDTH-1:0] avg_count
);

  localparam logic [3:0] ADDR_CTRL  = 4'h0;
  localparam logic [3:0] ADDR_NSAMP = 4'h4;
  localparam logic [3:0] ADDR_NAVG  = 4'h6;
  localparam logic [3:0] ADDR_COUNT = 4'hE;
`ifdef AVG_CTRL_IRQ_EN
  localparam logic [3:0] ADDR_GIE   = 4'h1;
  localparam logic [3:0] ADDR_IER   = 4'h2;
  localparam logic [3:0] ADDR_ISR   = 4'h3;
`endif

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_e;
  typedef enum logic       {RDIDLE, RDDATA}         rstate_e;

  wstate_e                 wstate_q, wstate_d;
  rstate_e                 rstate_q, rstate_d;
  logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                    arready_q, arready_d, rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic [C_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                    ap_start_q, ap_start_d, auto_restart_q, auto_restart_d;
  logic                    done_q, done_d, ready_q, ready_d;
  logic [C_DATA_WIDTH-1:0] num_samples_q, num_samples_d, num_avgs_q, num_avgs_d;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_ctrl, rd_ctrl;
`ifdef AVG_CTRL_IRQ_EN
  logic                    gie_q, gie_d, interrupt_q, interrupt_d;
  logic [1:0]              ier_q, ier_d, isr_q, isr_d;
`endif

  // Address bits below the word boundary are never decoded.
  logic unused_c;
  assign unused_c = ^{waddr_q[1:0], s_axi.araddr[1:0]};

  function automatic logic [C_DATA_WIDTH-1:0] merge_strb(input logic [C_DATA_WIDTH-1:0] old,
                                                         input logic [C_DATA_WIDTH-1:0] data,
                                                         input logic [3:0]              strb);
    logic [C_DATA_WIDTH-1:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  // Handshakes, channel FSMs and register next-state.
  always_comb begin
    aw_hs = awready_q & s_axi.awvalid;
    w_hs  = wready_q  & s_axi.wvalid;
    b_hs  = bvalid_q  & s_axi.bready;
    ar_hs = arready_q & s_axi.arvalid;
    r_hs  = rvalid_q  & s_axi.rready;

    wstate_d = wstate_q;
    case (wstate_q)
      WRIDLE:  if (aw_hs) wstate_d = WRDATA;
      WRDATA:  if (w_hs)  wstate_d = WRRESP;
      WRRESP:  if (b_hs)  wstate_d = WRIDLE;
      default:            wstate_d = WRIDLE;
    endcase
    awready_d = (wstate_d == WRIDLE);
    wready_d  = (wstate_d == WRDATA);
    bvalid_d  = (wstate_d == WRRESP);
    waddr_d   = aw_hs ? s_axi.awaddr : waddr_q;

    rstate_d = rstate_q;
    case (rstate_q)
      RDIDLE:  if (ar_hs) rstate_d = RDDATA;
      RDDATA:  if (r_hs)  rstate_d = RDIDLE;
      default:            rstate_d = RDIDLE;
    endcase
    arready_d = (rstate_d == RDIDLE);
    rvalid_d  = (rstate_d == RDDATA);

    rd_mux = '0;
    case (s_axi.araddr[5:2])
      ADDR_CTRL:  rd_mux = {24'd0, auto_restart_q, 3'd0, ready_q, ap_idle, done_q, ap_start_q};
      ADDR_NSAMP: rd_mux = num_samples_q;
      ADDR_NAVG:  rd_mux = num_avgs_q;
      ADDR_COUNT: rd_mux = avg_count;
`ifdef AVG_CTRL_IRQ_EN
      ADDR_GIE:   rd_mux = {31'd0, gie_q};
      ADDR_IER:   rd_mux = {30'd0, ier_q};
      ADDR_ISR:   rd_mux = {30'd0, isr_q};
`endif
      default:    rd_mux = '0;
    endcase
    rdata_d = ar_hs ? rd_mux : rdata_q;

    wr_ctrl = w_hs && (waddr_q[5:2] == ADDR_CTRL) && s_axi.wstrb[0];
    rd_ctrl = ar_hs && (s_axi.araddr[5:2] == ADDR_CTRL);

    auto_restart_d = wr_ctrl ? s_axi.wdata[7] : auto_restart_q;
    ap_start_d     = ap_start_q;
    if (ap_ready && !auto_restart_q) ap_start_d = 1'b0;
    if (wr_ctrl && s_axi.wdata[0])   ap_start_d = 1'b1;

    // A same-cycle event beats the read-to-clear.
    done_d  = ap_done  | (done_q  & ~rd_ctrl);
    ready_d = ap_ready | (ready_q & ~rd_ctrl);

    num_samples_d = num_samples_q;
    num_avgs_d    = num_avgs_q;
    if (w_hs && waddr_q[5:2] == ADDR_NSAMP)
      num_samples_d = merge_strb(num_samples_q, s_axi.wdata, s_axi.wstrb);
    if (w_hs && waddr_q[5:2] == ADDR_NAVG)
      num_avgs_d = merge_strb(num_avgs_q, s_axi.wdata, s_axi.wstrb);

`ifdef AVG_CTRL_IRQ_EN
    gie_d = gie_q;
    ier_d = ier_q;
    isr_d = isr_q;
    if (w_hs && s_axi.wstrb[0]) begin
      if (waddr_q[5:2] == ADDR_GIE) gie_d = s_axi.wdata[0];
      if (waddr_q[5:2] == ADDR_IER) ier_d = s_axi.wdata[1:0];
      if (waddr_q[5:2] == ADDR_ISR) isr_d = isr_q ^ s_axi.wdata[1:0];
    end
    isr_d       = isr_d | (ier_q & {ap_ready, ap_done});
    interrupt_d = gie_d & (|isr_d);
`endif
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wstate_q       <= WRIDLE;
      rstate_q       <= RDIDLE;
      awready_q      <= 1'b0;
      wready_q       <= 1'b0;
      bvalid_q       <= 1'b0;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      waddr_q        <= '0;
      ap_start_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      num_samples_q  <= '0;
      num_avgs_q     <= '0;
`ifdef AVG_CTRL_IRQ_EN
      gie_q          <= 1'b0;
      ier_q          <= 2'd0;
      isr_q          <= 2'd0;
      interrupt_q    <= 1'b0;
`endif
    end else begin
      wstate_q       <= wstate_d;
      rstate_q       <= rstate_d;
      awready_q      <= awready_d;
      wready_q       <= wready_d;
      bvalid_q       <= bvalid_d;
      arready_q      <= arready_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      waddr_q        <= waddr_d;
      ap_start_q     <= ap_start_d;
      auto_restart_q <= auto_restart_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
      num_samples_q  <= num_samples_d;
      num_avgs_q     <= num_avgs_d;
`ifdef AVG_CTRL_IRQ_EN
      gie_q          <= gie_d;
      ier_q          <= ier_d;
      isr_q          <= isr_d;
      interrupt_q    <= interrupt_d;
`endif
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;
  assign ap_start      = ap_start_q;
  assign num_samples   = num_samples_q;
  assign num_avgs      = num_avgs_q;
`ifdef AVG_CTRL_IRQ_EN
  assign interrupt     = interrupt_q;
`endif

endmodule

// File: tb/tb_avg_ctrl_s_axi.sv
// Randomized bench for avg_ctrl_s_axi against a register-level reference model.
module tb_avg_ctrl_s_axi;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start, ap_done, ap_ready, ap_idle;
  logic [31:0] num_samples, num_avgs, avg_count;
`ifdef AVG_CTRL_IRQ_EN
  logic        interrupt;
`endif

  always #5 ap_clk = ~ap_clk;

  avg_ctrl_s_axi_if #(.C_ADDR_WIDTH(6)) bus ();

  avg_ctrl_s_axi #(.C_ADDR_WIDTH(6), .C_DATA_WIDTH(32)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .s_axi       (bus),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .num_samples (num_samples),
    .num_avgs    (num_avgs),
`ifdef AVG_CTRL_IRQ_EN
    .interrupt   (interrupt),
`endif
    .avg_count   (avg_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: what software would see in the register map.
  logic        m_start, m_auto, m_done, m_ready;
  logic [31:0] m_ns, m_na;
  logic        m_gie;
  logic [1:0]  m_ier, m_isr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_start = 0; m_auto = 0; m_done = 0; m_ready = 0;
    m_ns = 0; m_na = 0; m_gie = 0; m_ier = 0; m_isr = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic model_write(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] strb);
    case (addr[5:2])
      4'd0: if (strb[0]) begin m_auto = d[7]; if (d[0]) m_start = 1; end
      4'd4: m_ns = merge(m_ns, d, strb);
      4'd6: m_na = merge(m_na, d, strb);
`ifdef AVG_CTRL_IRQ_EN
      4'd1: if (strb[0]) m_gie = d[0];
      4'd2: if (strb[0]) m_ier = d[1:0];
      4'd3: if (strb[0]) m_isr = m_isr ^ d[1:0];
`endif
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] addr);
    case (addr[5:2])
      4'd0:  return {24'd0, m_auto, 3'd0, m_ready, ap_idle, m_done, m_start};
      4'd4:  return m_ns;
      4'd6:  return m_na;
      4'd14: return avg_count;
`ifdef AVG_CTRL_IRQ_EN
      4'd1:  return {31'd0, m_gie};
      4'd2:  return {30'd0, m_ier};
      4'd3:  return {30'd0, m_isr};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] strb);
    @(negedge ap_clk);
    bus.awaddr = addr; bus.awvalid = 1; bus.wdata = d; bus.wstrb = strb; bus.wvalid = 1;
    for (int i = 0; i < 20 && !bus.awready; i++) @(negedge ap_clk);
    check("awready", 32'(bus.awready), 1);
    @(negedge ap_clk);
    bus.awvalid = 0;
    check("wready", 32'(bus.wready), 1);
    check("awready_low", 32'(bus.awready), 0);
    @(negedge ap_clk);
    bus.wvalid = 0;
    model_write(addr, d, strb);
    check("bvalid", 32'(bus.bvalid), 1);
    check("bresp", 32'(bus.bresp), 0);
    bus.bready = 1;
    @(negedge ap_clk);
    bus.bready = 0;
    check("bvalid_drop", 32'(bus.bvalid), 0);
  endtask

  task automatic axi_read(input logic [5:0] addr, input int hold, input bit bump,
                          output logic [31:0] d);
    logic [31:0] exp;
    @(negedge ap_clk);
    bus.araddr = addr; bus.arvalid = 1; bus.rready = 0;
    for (int i = 0; i < 20 && !bus.arready; i++) @(negedge ap_clk);
    check("arready", 32'(bus.arready), 1);
    exp = model_read(addr);
    if (addr[5:2] == 4'd0) begin m_done = 0; m_ready = 0; end
    @(negedge ap_clk);
    bus.arvalid = 0;
    check("rvalid", 32'(bus.rvalid), 1);
    check("rresp", 32'(bus.rresp), 0);
    check("rdata", bus.rdata, exp);
    d = bus.rdata;
    for (int i = 0; i < hold; i++) begin
      if (bump && i == 0) avg_count = avg_count + 1;
      @(negedge ap_clk);
      check("rvalid_hold", 32'(bus.rvalid), 1);
      check("rdata_hold", bus.rdata, exp);
      check("arready_hold", 32'(bus.arready), 0);
    end
    bus.rready = 1;
    @(negedge ap_clk);
    bus.rready = 0;
    check("rvalid_drop", 32'(bus.rvalid), 0);
  endtask

  task automatic pulse(input bit done, input bit rdy);
    @(negedge ap_clk);
    ap_done = done; ap_ready = rdy;
    m_done  = m_done | done;
    m_ready = m_ready | rdy;
    if (rdy && !m_auto) m_start = 0;
    m_isr = m_isr | (m_ier & {rdy, done});
    @(negedge ap_clk);
    ap_done = 0; ap_ready = 0;
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_ap_start"}, 32'(ap_start), 32'(m_start));
    check({tag, "_num_samples"}, num_samples, m_ns);
    check({tag, "_num_avgs"}, num_avgs, m_na);
`ifdef AVG_CTRL_IRQ_EN
    check({tag, "_interrupt"}, 32'(interrupt), 32'(m_gie & (|m_isr)));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [5:0]  a;
    bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
    ap_done = 0; ap_ready = 0; ap_idle = 1; avg_count = 0;
    model_reset();

    #1 ap_rst_n = 0;
    repeat (3) @(negedge ap_clk);
    check("rst_bvalid", 32'(bus.bvalid), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_rdata", bus.rdata, 0);
    check_ports("rst");
    ap_rst_n = 1;

    axi_read(6'h00, 0, 0, d);
    check("ctrl_after_reset", d, 32'h4);

    axi_write(6'h10, 32'd110592, 4'hF);
    axi_write(6'h18, 32'd5, 4'hF);
    check_ports("regs");
    axi_read(6'h10, 0, 0, d);
    check("nsamp_rb", d, 32'd110592);
    axi_read(6'h18, 0, 0, d);
    check("navg_rb", d, 32'd5);
    axi_write(6'h18, 32'hFFFF_FFFF, 4'b0001);
    axi_read(6'h18, 0, 0, d);
    check("navg_strb", d, 32'h0000_00FF);

    axi_write(6'h00, 32'd129, 4'hF);
    check("autostart_set", 32'(ap_start), 1);
    pulse(0, 1);
    check("autostart_keep", 32'(ap_start), 1);
    axi_write(6'h00, 32'd0, 4'hF);
    check("write0_noeffect", 32'(ap_start), 1);
    pulse(0, 1);
    check("start_clear", 32'(ap_start), 0);

    axi_write(6'h00, 32'd1, 4'hF);
    check("start_set", 32'(ap_start), 1);
    pulse(0, 1);
    pulse(1, 0);
    check("start_oneshot", 32'(ap_start), 0);
    axi_read(6'h00, 0, 0, d);
    check("ctrl_status_set", d, 32'h0000_000E);
    axi_read(6'h00, 0, 0, d);
    check("ctrl_status_clr", d, 32'h0000_0004);

    avg_count = 3;
    axi_read(6'h38, 10, 1, d);
    check("count_sampled", d, 32'd3);

`ifdef AVG_CTRL_IRQ_EN
    axi_write(6'h04, 32'd1, 4'hF);
    axi_write(6'h08, 32'd1, 4'hF);
    pulse(1, 0);
    check("irq_set", 32'(interrupt), 1);
    axi_write(6'h0C, 32'd1, 4'hF);
    check("irq_clr", 32'(interrupt), 0);
    axi_read(6'h00, 0, 0, d);
`endif

    // Reset in the middle of a write: the W beat is lost and every valid drops.
    @(negedge ap_clk);
    bus.awaddr = 6'h10; bus.awvalid = 1; bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1;
    for (int i = 0; i < 20 && !bus.awready; i++) @(negedge ap_clk);
    check("mid_awready", 32'(bus.awready), 1);
    @(negedge ap_clk);
    check("mid_wready", 32'(bus.wready), 1);
    #1 ap_rst_n = 0;
    #1;
    check("mid_rst_wready", 32'(bus.wready), 0);
    check("mid_rst_bvalid", 32'(bus.bvalid), 0);
    check("mid_rst_rvalid", 32'(bus.rvalid), 0);
    bus.awvalid = 0; bus.wvalid = 0;
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1;
    check_ports("mid_rst");

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 6'($urandom_range(0, 63));
          axi_write(a, $urandom, 4'($urandom_range(0, 15)));
        end
        1: begin
          a = 6'($urandom_range(0, 63));
          axi_read(a, $urandom_range(0, 2), 0, d);
        end
        2: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          @(negedge ap_clk);
          ap_idle = 1'($urandom_range(0, 1));
          avg_count = $urandom;
        end
      endcase
      check_ports("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
